// File: rtl/wb_deserializer.sv
// rtl/wb_deserializer.sv - serial-to-parallel receiver with Wishbone register access and receive FIFO
//
// Ports:
//   CLK_I, RST_NI        clock (rising edge), asynchronous active-low reset
//   data_i, ena_i        serial bit (MSB first) and its per-cycle valid strobe
//   CYC_I, STB_I, WE_I   Wishbone classic cycle / strobe / write-enable
//   ADR_I[1:0]           0 RXDATA (RO, pops), 1 STATUS (W1C bits 2-3), 2 CTRL, 3 invalid
//   DAT_I[31:0]          write data
//   ACK_O, ERR_O         one-cycle registered response
//   DAT_O[31:0]          read data, held until the next response
//   irq_o                FIFO non-empty and CTRL.irq_en
module wb_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic        data_i,
    input  logic        ena_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [1:0]  ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_rx_en;
    logic                  r_irq_en;
    logic                  r_ovf;
    logic                  r_frame_err;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_dat;

    logic                  w_req;
    logic                  w_bus_err;
    logic                  w_bus_ack;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_ctrl_wr;
    logic                  w_w1c_ovf;
    logic                  w_w1c_ferr;
    logic                  w_bit_en;
    logic                  w_word_done;
    logic                  w_push;
    logic                  w_ovf_set;
    logic                  w_ferr_set;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [31:0]           w_status;
    logic [31:0]           w_rdata;
    logic                  w_unused;

    // A new request is only taken while no response is on the bus, so a
    // held strobe is answered every other cycle.
    assign w_req     = CYC_I & STB_I & ~r_ack & ~r_err;
    assign w_bus_err = w_req & (((ADR_I == 2'd0) & WE_I) | (ADR_I == 2'd3));
    assign w_bus_ack = w_req & ~w_bus_err;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);

    assign w_pop      = w_bus_ack & (ADR_I == 2'd0) & ~WE_I & ~w_empty;
    assign w_ctrl_wr  = w_bus_ack & (ADR_I == 2'd2) & WE_I;
    assign w_flush    = w_ctrl_wr & DAT_I[2];
    assign w_w1c_ovf  = w_bus_ack & (ADR_I == 2'd1) & WE_I & DAT_I[2];
    assign w_w1c_ferr = w_bus_ack & (ADR_I == 2'd1) & WE_I & DAT_I[3];

    assign w_bit_en     = r_rx_en & ena_i;
    assign w_word_done  = w_bit_en & (r_bit_cnt == LAST_BIT);
    assign w_shift_next = (r_shift << 1) | DATA_WIDTH'(data_i);

    // A completing word is kept only if there is room or the same edge pops;
    // a flush on that edge discards it without touching the sticky flags.
    assign w_push     = w_word_done & ~w_flush & (~w_full | w_pop);
    assign w_ovf_set  = w_word_done & ~w_flush & w_full & ~w_pop;
    assign w_ferr_set = r_rx_en & ~ena_i & (r_bit_cnt != '0) & ~w_flush;

    assign w_unused = &{1'b0, DAT_I[31:4]};

    always_comb begin
        w_status             = '0;
        w_status[0]          = w_empty;
        w_status[1]          = w_full;
        w_status[2]          = r_ovf;
        w_status[3]          = r_frame_err;
        w_status[8 +: CW]    = r_count;
    end

    always_comb begin
        w_rdata = '0;
        if (!WE_I) begin
            case (ADR_I)
                2'd0:    w_rdata = w_empty ? 32'd0 : 32'(r_mem[r_rd_ptr]);
                2'd1:    w_rdata = w_status;
                2'd2:    w_rdata = {30'd0, r_irq_en, r_rx_en};
                default: w_rdata = '0;
            endcase
        end
    end

    // Storage array is left unreset; the pointers and count define validity.
    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_shift_next;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_rx_en     <= 1'b0;
            r_irq_en    <= 1'b0;
            r_ovf       <= 1'b0;
            r_frame_err <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat       <= '0;
        end else begin
            r_ack <= w_bus_ack;
            r_err <= w_bus_err;
            if (w_bus_ack || w_bus_err) begin
                r_dat <= w_bus_err ? 32'd0 : w_rdata;
            end

            if (w_ctrl_wr) begin
                r_rx_en  <= DAT_I[0];
                r_irq_en <= DAT_I[1];
            end

            // Counter advances only mid-word; completion, flush, a dropped
            // strobe (framing error) or rx disabled all return it to 0.
            if (w_bit_en) begin
                r_shift <= w_shift_next;
            end
            if (w_bit_en && !w_flush && !w_word_done) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
                r_bit_cnt <= '0;
            end

            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            // Set wins over a write-1-to-clear on the same edge.
            r_ovf       <= w_ovf_set  | (r_ovf       & ~w_w1c_ovf);
            r_frame_err <= w_ferr_set | (r_frame_err & ~w_w1c_ferr);
        end
    end

    assign ACK_O = r_ack;
    assign ERR_O = r_err;
    assign DAT_O = r_dat;
    assign irq_o = r_irq_en & ~w_empty;

endmodule

// File: tb/tb_wb_deserializer.sv
// tb/tb_wb_deserializer.sv - directed self-checking bench for wb_deserializer
module tb_wb_deserializer;

    logic        CLK_I = 1'b0;
    logic        RST_NI;
    logic        data_i;
    logic        ena_i;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [1:0]  ADR_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic        ERR_O;
    logic [31:0] DAT_O;
    logic        irq_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK_I = ~CLK_I;

    wb_deserializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .CLK_I (CLK_I),
        .RST_NI(RST_NI),
        .data_i(data_i),
        .ena_i (ena_i),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .WE_I  (WE_I),
        .ADR_I (ADR_I),
        .DAT_I (DAT_I),
        .ACK_O (ACK_O),
        .ERR_O (ERR_O),
        .DAT_O (DAT_O),
        .irq_o (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ack, output logic err);
        int k;
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
        for (k = 0; k < 4; k++) begin
            @(posedge CLK_I);
            #1;
            if (ACK_O || ERR_O) break;
        end
        ack = ACK_O;
        err = ERR_O;
        rd  = DAT_O;
        @(negedge CLK_I);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
        if (k == 4) check("bus_timeout", 32'd1, 32'd0);
    endtask

    task automatic rd_reg(input logic [1:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic ack, err;
        bus(1'b0, adr, 32'd0, rd, ack, err);
        check(tag, rd, exp);
    endtask

    task automatic wr_reg(input logic [1:0] adr, input logic [31:0] val);
        logic [31:0] rd;
        logic ack, err;
        bus(1'b1, adr, val, rd, ack, err);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge CLK_I);
            ena_i = 1'b1; data_i = v[i];
        end
        @(negedge CLK_I);
        ena_i = 1'b0; data_i = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic ack, err;
        int acks;
        logic [7:0] w77;

        RST_NI = 1'b0; data_i = 1'b0; ena_i = 1'b0;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 2'd0; DAT_I = '0;
        repeat (3) @(posedge CLK_I);
        #1;
        check("rst_ack", {31'd0, ACK_O}, 32'd0);
        check("rst_err", {31'd0, ERR_O}, 32'd0);
        check("rst_dat", DAT_O, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge CLK_I);
        RST_NI = 1'b1;

        // single word A5
        bus(1'b1, 2'd2, 32'h3, rd, ack, err);
        check("ctrl_wr_ack", {30'd0, ack, err}, 32'h2);
        send_bits(32'hA5, 8);
        check("irq_set", {31'd0, irq_o}, 32'd1);
        rd_reg(2'd1, 32'h100, "status_one");
        rd_reg(2'd0, 32'hA5, "rx_a5");
        rd_reg(2'd1, 32'h001, "status_empty");
        check("irq_clr", {31'd0, irq_o}, 32'd0);

        // overflow with five words
        for (int w = 1; w <= 5; w++) send_bits(32'(w), 8);
        rd_reg(2'd1, 32'h406, "status_ovf");
        for (int w = 1; w <= 4; w++) rd_reg(2'd0, 32'(w), "rx_seq");
        rd_reg(2'd1, 32'h005, "status_ovf_empty");
        wr_reg(2'd1, 32'h4);
        rd_reg(2'd1, 32'h001, "status_w1c_ovf");

        // framing error then a good frame
        send_bits(32'h5, 3);
        rd_reg(2'd1, 32'h009, "status_ferr");
        send_bits(32'h3C, 8);
        rd_reg(2'd0, 32'h3C, "rx_3c");
        wr_reg(2'd1, 32'h8);
        rd_reg(2'd1, 32'h001, "status_w1c_ferr");

        // push and pop on the same edge while full
        for (int w = 0; w < 4; w++) send_bits(32'h10 + 32'(w), 8);
        rd_reg(2'd1, 32'h402, "status_full");
        w77 = 8'h77;
        for (int i = 7; i >= 1; i--) begin
            @(negedge CLK_I);
            ena_i = 1'b1; data_i = w77[i];
        end
        @(negedge CLK_I);
        ena_i = 1'b1; data_i = w77[0];
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 2'd0;
        @(posedge CLK_I);
        #1;
        check("coinc_ack", {31'd0, ACK_O}, 32'd1);
        check("coinc_dat", DAT_O, 32'h10);
        @(negedge CLK_I);
        ena_i = 1'b0; data_i = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
        rd_reg(2'd1, 32'h402, "status_coinc");
        rd_reg(2'd0, 32'h11, "rx_11");
        rd_reg(2'd0, 32'h12, "rx_12");
        rd_reg(2'd0, 32'h13, "rx_13");
        rd_reg(2'd0, 32'h77, "rx_77");
        rd_reg(2'd0, 32'h0, "rx_empty");

        // error responses, CTRL readback, flush
        bus(1'b1, 2'd0, 32'hFF, rd, ack, err);
        check("rxdata_wr_resp", {30'd0, ack, err}, 32'h1);
        bus(1'b0, 2'd3, 32'd0, rd, ack, err);
        check("adr3_resp", {30'd0, ack, err}, 32'h1);
        send_bits(32'h55, 8);
        send_bits(32'hAA, 8);
        rd_reg(2'd1, 32'h200, "status_two");
        wr_reg(2'd2, 32'h7);
        rd_reg(2'd2, 32'h3, "ctrl_rd");
        rd_reg(2'd1, 32'h001, "status_flushed");

        // held strobe answers every other cycle
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 2'd1;
        acks = 0;
        repeat (4) begin
            @(posedge CLK_I);
            #1;
            acks += int'(ACK_O);
        end
        @(negedge CLK_I);
        CYC_I = 1'b0; STB_I = 1'b0;
        check("held_strobe", 32'(acks), 32'd2);

        // reset mid-frame and mid-strobe
        send_bits(32'h42, 8);
        check("irq_pre_rst", {31'd0, irq_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_I);
            ena_i = 1'b1; data_i = 1'b1;
        end
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 2'd2;
        #2;
        RST_NI = 1'b0;
        #1;
        check("mid_rst_outs", {ACK_O, ERR_O, irq_o, DAT_O[28:0]}, 32'd0);
        @(negedge CLK_I);
        CYC_I = 1'b0; STB_I = 1'b0; ena_i = 1'b0; data_i = 1'b0;
        @(negedge CLK_I);
        RST_NI = 1'b1;
        rd_reg(2'd1, 32'h001, "status_after_rst");
        rd_reg(2'd2, 32'h0, "ctrl_after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
